// File: rtl/sample_pacer_pkg.sv
// Shared state encoding and elaboration-time helpers for the sample pacer.
package sample_pacer_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    EMIT = ST_EMIT
  } state_e;

  // Width of one packed frame; the top builds its frame_t from this.
  function automatic int frame_width(input int channels, input int data_width);
    return channels * data_width;
  endfunction

  // Rounded phase increment: sample_freq * 2^acc_width / clk_freq, in 64-bit arithmetic.
  function automatic longint unsigned calc_inc(input longint unsigned sample_freq,
                                               input longint unsigned clk_freq,
                                               input int              acc_width);
    return ((sample_freq << acc_width) + (clk_freq >> 1)) / clk_freq;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/level; DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic [LW-1:0]    level_s;
  logic             full_r;
  logic             empty_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push & ~full_r;
  assign pop_ok_s  = pop & ~empty_r;

  // Occupancy after this cycle's accepted push and pop.
  always_comb begin
    level_s = level_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_s = level_r + LW'(1'b1);
      2'b01:   level_s = level_r - LW'(1'b1);
      default: level_s = level_r;
    endcase
  end

  // Pointers, occupancy and flags; flags come from the next level so they never lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      level_r <= level_s;
      full_r  <= (level_s == LVL_FULL);
      empty_r <= (level_s == '0);
    end
  end

  // Frame storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign full     = full_r;
  assign empty    = empty_r;
  assign level    = level_r;

endmodule

// File: rtl/sample_pacer.sv
// Buffers frames from the driver and releases them at SAMPLE_FREQ, derived from clk
// by a fractional phase accumulator; parallel or one-channel-per-cycle output.
module sample_pacer
  import sample_pacer_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH        = 16,
  parameter int SAMPLE_FREQ  = 48000,
  parameter int DUT_CLK_FREQ = 100000000,
  parameter int ACC_WIDTH    = 32,
  parameter bit SERIAL       = 1'b0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             enable,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0]   s_data,
  output logic                             m_valid,
  output logic [CHANNELS*DATA_WIDTH-1:0]   m_data,
  output logic [$clog2(CHANNELS):0]        m_channel,
  output logic                             m_last,
  output logic [$clog2(DEPTH):0]           level,
  output logic                             underrun,
  output logic                             overrun
);

  localparam int FW = frame_width(CHANNELS, DATA_WIDTH);
  localparam int CW = $clog2(CHANNELS) + 1;
  localparam longint unsigned INC_L = calc_inc(64'(SAMPLE_FREQ), 64'(DUT_CLK_FREQ), ACC_WIDTH);
  localparam logic [ACC_WIDTH-1:0] INC = INC_L[ACC_WIDTH-1:0];
  localparam logic [CW-1:0] LAST_IDX = CW'(CHANNELS - 1);

  typedef logic [FW-1:0] frame_t;

  if (INC_L == 64'd0 || (ACC_WIDTH < 64 && INC_L >= (64'd1 << ACC_WIDTH))) begin : g_bad_rate
    $error("sample_pacer: phase increment out of range");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sample_pacer: DEPTH must be a power of two >= 2");
  end

  logic [ACC_WIDTH-1:0] acc_r;
  logic [ACC_WIDTH:0]   sum_s;
  logic                 tick_s;
  logic                 pop_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  frame_t               head_s;
  frame_t               take_s;
  state_e               state_r, state_s;
  logic [CW-1:0]        idx_r, idx_s, idx_nx_s;
  frame_t               frame_r, frame_s;
  logic                 m_valid_r, m_valid_s;
  logic                 m_last_r, m_last_s;
  frame_t               m_data_r, m_data_s;
  logic [CW-1:0]        m_channel_r, m_channel_s;
  logic                 underrun_r, underrun_s;
  logic                 overrun_r, overrun_s;

  function automatic frame_t sample_of(input frame_t f, input logic [CW-1:0] i);
    frame_t s;
    s = '0;
    s[DATA_WIDTH-1:0] = f[int'(i)*DATA_WIDTH +: DATA_WIDTH];
    return s;
  endfunction

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (s_valid),
    .push_data (s_data),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (level)
  );

  assign s_ready = ~fifo_full_s;

  // The carry out of the accumulator is the rate tick.
  assign sum_s  = {1'b0, acc_r} + {1'b0, INC};
  assign tick_s = enable & sum_s[ACC_WIDTH];

  // Phase accumulator; held at zero while pacing is disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_r <= '0;
    end else if (enable) begin
      acc_r <= sum_s[ACC_WIDTH-1:0];
    end else begin
      acc_r <= '0;
    end
  end

  // An empty FIFO at tick time repeats the previously emitted frame.
  assign take_s   = fifo_empty_s ? frame_r : head_s;
  assign pop_s    = tick_s & ~fifo_empty_s & (~SERIAL | (state_r == IDLE));
  assign idx_nx_s = idx_r + CW'(1'b1);

  // Next output beat and sequencing; outputs are computed one cycle ahead and registered.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    frame_s     = frame_r;
    m_valid_s   = 1'b0;
    m_last_s    = 1'b0;
    m_channel_s = '0;
    m_data_s    = m_data_r;
    underrun_s  = underrun_r;
    overrun_s   = overrun_r;
    if (!SERIAL) begin
      if (tick_s) begin
        frame_s    = take_s;
        m_data_s   = take_s;
        m_valid_s  = 1'b1;
        m_last_s   = 1'b1;
        underrun_s = underrun_r | fifo_empty_s;
      end else begin
        frame_s = frame_r;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (tick_s) begin
            frame_s     = take_s;
            state_s     = EMIT;
            idx_s       = '0;
            m_valid_s   = 1'b1;
            m_channel_s = '0;
            m_data_s    = sample_of(take_s, '0);
            m_last_s    = (LAST_IDX == '0);
            underrun_s  = underrun_r | fifo_empty_s;
          end else begin
            state_s = IDLE;
          end
        end
        EMIT: begin
          overrun_s = overrun_r | tick_s;
          if (idx_r == LAST_IDX) begin
            state_s = IDLE;
          end else begin
            idx_s       = idx_nx_s;
            m_valid_s   = 1'b1;
            m_channel_s = idx_nx_s;
            m_data_s    = sample_of(frame_r, idx_nx_s);
            m_last_s    = (idx_nx_s == LAST_IDX);
          end
        end
        default: begin
          state_s = IDLE;
          idx_s   = '0;
        end
      endcase
    end
  end

  // Sequencer state, last-frame register, output beat and sticky flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      frame_r     <= '0;
      m_valid_r   <= 1'b0;
      m_last_r    <= 1'b0;
      m_channel_r <= '0;
      m_data_r    <= '0;
      underrun_r  <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      frame_r     <= frame_s;
      m_valid_r   <= m_valid_s;
      m_last_r    <= m_last_s;
      m_channel_r <= m_channel_s;
      m_data_r    <= m_data_s;
      underrun_r  <= underrun_s;
      overrun_r   <= overrun_s;
    end
  end

  assign m_valid   = m_valid_r;
  assign m_last    = m_last_r;
  assign m_channel = m_channel_r;
  assign m_data    = m_data_r;
  assign underrun  = underrun_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_sample_pacer.sv
// Bench for sample_pacer: a parallel and a serial instance, checked one at a time
// against a frame-queue / beat-schedule reference model.
module tb_sample_pacer;

  localparam int CH  = 4;
  localparam int DW  = 16;
  localparam int DEP = 4;
  localparam int AW  = 8;

  typedef struct {
    logic [63:0] data;
    int          ch;
    bit          last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  bit          cur;
  logic        en, sv;
  logic [63:0] sdata;

  logic        en_p, sv_p, rdy_p, mv_p, ml_p, ur_p, or_p;
  logic [63:0] md_p;
  logic [2:0]  mc_p, lv_p;
  logic        en_s, sv_s, rdy_s, mv_s, ml_s, ur_s, or_s;
  logic [63:0] md_s;
  logic [2:0]  mc_s, lv_s;

  logic        obs_ready, obs_valid, obs_last, obs_under, obs_over;
  logic [63:0] obs_data;
  logic [2:0]  obs_ch, obs_level;

  int checks = 0;
  int errors = 0;

  logic [63:0] mq[$];
  beat_t       pend[$];
  int          vq[$];
  bit          exp_valid, exp_last, exp_ready, exp_under, exp_over, ser_m;
  logic [63:0] exp_data, last_frame;
  int          exp_ch, exp_level;
  longint      k, inc_m;

  always #5 clk = ~clk;

  assign en_p = en & ~cur;
  assign sv_p = sv & ~cur;
  assign en_s = en & cur;
  assign sv_s = sv & cur;

  assign obs_ready = cur ? rdy_s : rdy_p;
  assign obs_valid = cur ? mv_s : mv_p;
  assign obs_last  = cur ? ml_s : ml_p;
  assign obs_under = cur ? ur_s : ur_p;
  assign obs_over  = cur ? or_s : or_p;
  assign obs_data  = cur ? md_s : md_p;
  assign obs_ch    = cur ? mc_s : mc_p;
  assign obs_level = cur ? lv_s : lv_p;

  sample_pacer #(
    .CHANNELS(CH), .DATA_WIDTH(DW), .DEPTH(DEP), .SAMPLE_FREQ(1),
    .DUT_CLK_FREQ(4), .ACC_WIDTH(AW), .SERIAL(1'b0)
  ) u_par (
    .clk(clk), .reset_n(reset_n), .enable(en_p), .s_valid(sv_p), .s_ready(rdy_p),
    .s_data(sdata), .m_valid(mv_p), .m_data(md_p), .m_channel(mc_p), .m_last(ml_p),
    .level(lv_p), .underrun(ur_p), .overrun(or_p)
  );

  sample_pacer #(
    .CHANNELS(CH), .DATA_WIDTH(DW), .DEPTH(DEP), .SAMPLE_FREQ(100),
    .DUT_CLK_FREQ(297), .ACC_WIDTH(AW), .SERIAL(1'b1)
  ) u_ser (
    .clk(clk), .reset_n(reset_n), .enable(en_s), .s_valid(sv_s), .s_ready(rdy_s),
    .s_data(sdata), .m_valid(mv_s), .m_data(md_s), .m_channel(mc_s), .m_last(ml_s),
    .level(lv_s), .underrun(ur_s), .overrun(or_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint round_inc(input longint sf, input longint dc);
    return (sf * (64'd1 << AW) * 2 + dc) / (2 * dc);
  endfunction

  task automatic model_reset();
    mq.delete();
    pend.delete();
    exp_valid  = 1'b0;
    exp_last   = 1'b0;
    exp_ready  = 1'b1;
    exp_under  = 1'b0;
    exp_over   = 1'b0;
    exp_data   = 64'd0;
    exp_ch     = 0;
    exp_level  = 0;
    last_frame = 64'd0;
    k          = 0;
    ser_m      = cur;
    inc_m      = cur ? round_inc(100, 297) : round_inc(1, 4);
  endtask

  task automatic do_reset();
    en = 1'b0;
    sv = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  // One clock: compare this cycle's outputs, then advance the model with this cycle's inputs.
  task automatic step();
    bit    push, tick, busy;
    beat_t b;
    @(negedge clk);
    check("s_ready", obs_ready, exp_ready);
    check("level", obs_level, exp_level);
    check("m_valid", obs_valid, exp_valid);
    check("m_last", obs_last, exp_last);
    check("underrun", obs_under, exp_under);
    check("overrun", obs_over, exp_over);
    if (exp_valid) begin
      check("m_data", obs_data, exp_data);
      check("m_channel", obs_ch, exp_ch);
    end
    push = sv && exp_ready;
    tick = en && ((((k + 1) * inc_m) >> AW) != ((k * inc_m) >> AW));
    k    = en ? k + 1 : 0;
    busy = ser_m && exp_valid;
    if (tick) begin
      if (busy) begin
        exp_over = 1'b1;
      end else begin
        if (mq.size() > 0) last_frame = mq.pop_front();
        else exp_under = 1'b1;
        if (ser_m) begin
          for (int c = 0; c < CH; c++) begin
            b.data = (last_frame >> (DW * c)) & 64'hFFFF;
            b.ch   = c;
            b.last = (c == CH - 1);
            pend.push_back(b);
          end
        end else begin
          b.data = last_frame;
          b.ch   = 0;
          b.last = 1'b1;
          pend.push_back(b);
        end
      end
    end
    if (push) mq.push_back(sdata);
    exp_level = mq.size();
    exp_ready = (exp_level < DEP);
    if (pend.size() > 0) begin
      b         = pend.pop_front();
      exp_valid = 1'b1;
      exp_data  = b.data;
      exp_ch    = b.ch;
      exp_last  = b.last;
    end else begin
      exp_valid = 1'b0;
      exp_last  = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] f [6];
    int          j;
    bit          a, found;

    cur   = 1'b0;
    en    = 1'b0;
    sv    = 1'b0;
    sdata = 64'd0;
    do_reset();
    check("rst_m_data", obs_data, 64'd0);

    // Rate: three frames queued, then pacing; m_valid expected at enabled cycles 5, 9, 13.
    sv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sdata = {$urandom, $urandom};
      step();
    end
    sv = 1'b0;
    en = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      step();
      if (obs_valid === 1'b1) vq.push_back(i + 1);
    end
    check("t1_valid_count", vq.size(), 3);
    for (int i = 0; i < 3 && i < vq.size(); i++) check("t1_valid_cycle", vq[i], 5 + 4 * i);

    // Underrun: a single frame, the second tick repeats it.
    do_reset();
    sv    = 1'b1;
    sdata = 64'h0004_0003_0002_0001;
    step();
    sv = 1'b0;
    en = 1'b1;
    repeat (10) step();
    check("t2_underrun", obs_under, 1'b1);
    for (int i = 0; i < 20; i++) begin
      sv    = $urandom_range(0, 1);
      sdata = {$urandom, $urandom};
      step();
    end

    // Back-pressure: six frames offered with s_valid held.
    do_reset();
    for (int i = 0; i < 6; i++) f[i] = {$urandom, $urandom};
    j  = 0;
    sv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sdata = f[j];
      a     = exp_ready;
      step();
      if (a) j++;
    end
    check("t3_ready_low", obs_ready, 1'b0);
    check("t3_level_full", obs_level, 4);
    en = 1'b1;
    for (int i = 0; i < 40 && j < 6; i++) begin
      sdata = f[j];
      a     = exp_ready;
      step();
      if (a) j++;
    end
    sv = 1'b0;
    check("t3_all_accepted", j, 6);
    repeat (30) step();

    // Serial emission and overrun on the fast-tick serial instance.
    cur = 1'b1;
    do_reset();
    sv    = 1'b1;
    sdata = 64'hDDDD_CCCC_BBBB_AAAA;
    step();
    for (int i = 0; i < 2; i++) begin
      sdata = {$urandom, $urandom};
      step();
    end
    sv = 1'b0;
    en = 1'b1;
    repeat (30) step();
    check("t5_overrun", obs_over, 1'b1);

    // Reset while channel 2 of a frame is on the output.
    do_reset();
    sv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sdata = {$urandom, $urandom};
      step();
    end
    sv    = 1'b0;
    en    = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (exp_valid && exp_ch == 2) found = 1'b1;
    end
    check("t6_found_idx2", found, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_m_valid", obs_valid, 1'b0);
    check("t6_async_level", obs_level, 0);
    en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    en = 1'b1;
    repeat (12) step();

    // Randomized traffic on both instances.
    for (int m = 0; m < 2; m++) begin
      cur = (m == 1);
      do_reset();
      for (int i = 0; i < 300; i++) begin
        en    = ($urandom_range(0, 15) != 0);
        sv    = ($urandom_range(0, 2) == 0);
        sdata = {$urandom, $urandom};
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
